// File: rtl/pc_unit.sv
// Program-counter unit: N-way source select, registered PC with conditional write,
// and an exception redirect sequencer that fetches the handler address from memory.
module pc_unit #(
    parameter int unsigned       WIDTH        = 32,
    parameter int unsigned       NSRC         = 5,
    parameter int unsigned       SELW         = 3,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
    parameter int unsigned       EXC_BASE     = 253,
    parameter int unsigned       MEM_LAT      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SELW-1:0]       src_sel,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic                  pc_write,
    input  logic                  pc_write_cond,
    input  logic                  cond_flag,
    input  logic                  exc_req,
    input  logic [1:0]            exc_code,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic [WIDTH-1:0]      pc,
    output logic [WIDTH-1:0]      epc,
    output logic [WIDTH-1:0]      exc_addr,
    output logic                  exc_mem_rd,
    output logic                  busy,
    output logic                  exc_ack,
    output logic                  illegal_sel
);

    localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;

    typedef enum logic {StIdle, StExcRd} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic             ill_q, ill_d;

    logic             load;
    logic             sel_ok;
    logic [WIDTH-1:0] sel_data;

    assign load   = pc_write | (pc_write_cond & cond_flag);
    assign sel_ok = 32'(src_sel) < NSRC;

    // Loop mux keeps out-of-range selects from indexing past src_data.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (32'(src_sel) == i) sel_data = src_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        ill_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (exc_req) begin
                    epc_d   = pc_q - WIDTH'(4);
                    addr_d  = WIDTH'(EXC_BASE) + WIDTH'(exc_code);
                    cnt_d   = CW'(MEM_LAT);
                    state_d = StExcRd;
                end else if (load) begin
                    if (sel_ok) pc_d = sel_data;
                    else        ill_d = 1'b1;
                end
            end
            StExcRd: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    pc_d    = mem_rdata;
                    ack_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            ill_q   <= ill_d;
        end
    end

    // Decoded from state so reset drops them asynchronously.
    assign busy        = (state_q == StExcRd);
    assign exc_mem_rd  = (state_q == StExcRd);
    assign pc          = pc_q;
    assign epc         = epc_q;
    assign exc_addr    = addr_q;
    assign exc_ack     = ack_q;
    assign illegal_sel = ill_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (NSRC=5, MEM_LAT=2).
module tb_pc_unit;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NSRC  = 5;
    localparam int unsigned SELW  = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [SELW-1:0]       src_sel;
    logic [NSRC*WIDTH-1:0] src_data;
    logic                  pc_write, pc_write_cond, cond_flag, exc_req;
    logic [1:0]            exc_code;
    logic [WIDTH-1:0]      mem_rdata;
    logic [WIDTH-1:0]      pc, epc, exc_addr;
    logic                  exc_mem_rd, busy, exc_ack, illegal_sel;

    int checks   = 0;
    int failures = 0;

    pc_unit #(
        .WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW), .RESET_VECTOR('0),
        .EXC_BASE(253), .MEM_LAT(2)
    ) dut (
        .clk(clk), .reset(reset), .src_sel(src_sel), .src_data(src_data),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .cond_flag(cond_flag),
        .exc_req(exc_req), .exc_code(exc_code), .mem_rdata(mem_rdata),
        .pc(pc), .epc(epc), .exc_addr(exc_addr), .exc_mem_rd(exc_mem_rd),
        .busy(busy), .exc_ack(exc_ack), .illegal_sel(illegal_sel)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; src_sel = '0; src_data = '0; pc_write = 0; pc_write_cond = 0;
        cond_flag = 0; exc_req = 0; exc_code = 0; mem_rdata = '0;
        src_data[0*32 +: 32] = 32'h0000_0088;
        src_data[1*32 +: 32] = 32'h0000_0104;
        src_data[2*32 +: 32] = 32'h0000_0040;
        src_data[3*32 +: 32] = 32'h0000_0000;
        src_data[4*32 +: 32] = 32'h0000_1234;
        #12;
        check("rst_pc", pc, 32'h0);
        check("rst_epc", epc, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_memrd", {31'b0, exc_mem_rd}, 32'h0);
        check("rst_addr", exc_addr, 32'h0);
        check("rst_ack", {31'b0, exc_ack}, 32'h0);
        check("rst_ill", {31'b0, illegal_sel}, 32'h0);
        @(negedge clk); reset = 1'b0;

        // Unconditional write from source 2
        src_sel = 3'd2; pc_write = 1; tick(); pc_write = 0;
        check("wr_src2", pc, 32'h40);
        check("wr_epc", epc, 32'h0);
        check("wr_busy", {31'b0, busy}, 32'h0);

        // Conditional write, condition false then true
        src_sel = 3'd0; pc_write_cond = 1; cond_flag = 0; tick();
        check("cond_false", pc, 32'h40);
        cond_flag = 1; tick(); pc_write_cond = 0; cond_flag = 0;
        check("cond_true", pc, 32'h88);

        // pc_write dominates pc_write_cond with cond_flag low
        src_sel = 3'd4; pc_write = 1; pc_write_cond = 1; tick();
        pc_write = 0; pc_write_cond = 0;
        check("wr_dom", pc, 32'h1234);

        // Illegal select
        src_sel = 3'd6; pc_write = 1; tick(); pc_write = 0;
        check("ill_pc", pc, 32'h1234);
        check("ill_pulse", {31'b0, illegal_sel}, 32'h1);
        tick();
        check("ill_clear", {31'b0, illegal_sel}, 32'h0);

        // Exception from pc=0x104 with a competing pc_write held throughout
        src_sel = 3'd1; pc_write = 1; tick();
        check("pc_104", pc, 32'h104);
        src_sel = 3'd2; exc_req = 1; exc_code = 2'd1; mem_rdata = 32'h80; tick();
        exc_req = 0;
        check("exc_epc", epc, 32'h100);
        check("exc_addr", exc_addr, 32'd254);
        check("exc_busy0", {31'b0, busy}, 32'h1);
        check("exc_rd0", {31'b0, exc_mem_rd}, 32'h1);
        check("exc_pc0", pc, 32'h104);
        tick();
        check("exc_busy1", {31'b0, busy}, 32'h1);
        check("exc_rd1", {31'b0, exc_mem_rd}, 32'h1);
        check("exc_pc1", pc, 32'h104);
        check("exc_ack_early", {31'b0, exc_ack}, 32'h0);
        tick(); pc_write = 0;
        check("exc_pc_load", pc, 32'h80);
        check("exc_busy_done", {31'b0, busy}, 32'h0);
        check("exc_ack", {31'b0, exc_ack}, 32'h1);
        check("exc_epc_hold", epc, 32'h100);
        tick();
        check("exc_ack_clear", {31'b0, exc_ack}, 32'h0);
        check("exc_pc_hold", pc, 32'h80);

        // Exception at pc=0 wins over pc_write
        src_sel = 3'd3; pc_write = 1; tick();
        check("pc_zero", pc, 32'h0);
        src_sel = 3'd2; exc_req = 1; exc_code = 2'd0; tick();
        exc_req = 0; pc_write = 0;
        check("wrap_epc", epc, 32'hFFFF_FFFC);
        check("wrap_pc", pc, 32'h0);
        check("wrap_busy", {31'b0, busy}, 32'h1);
        check("wrap_addr", exc_addr, 32'd253);
        tick(); tick();
        check("wrap_done", {31'b0, busy}, 32'h0);

        // Reset mid-fetch
        src_sel = 3'd0; pc_write = 1; tick(); pc_write = 0;
        check("pc_88", pc, 32'h88);
        exc_req = 1; exc_code = 2'd2; mem_rdata = 32'h55; tick(); exc_req = 0;
        check("abort_epc_pre", epc, 32'h84);
        check("abort_addr_pre", exc_addr, 32'd255);
        #2 reset = 1'b1;
        #1;
        check("abort_pc", pc, 32'h0);
        check("abort_epc", epc, 32'h0);
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_memrd", {31'b0, exc_mem_rd}, 32'h0);
        @(negedge clk); reset = 1'b0;
        tick();
        check("abort_ack0", {31'b0, exc_ack}, 32'h0);
        check("abort_pc0", pc, 32'h0);
        tick();
        check("abort_ack1", {31'b0, exc_ack}, 32'h0);
        check("abort_busy1", {31'b0, busy}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the multicycle CPU: N-way PC source select, registered PC with unconditional and conditional write, illegal-select detection.
- Built-in exception redirect sequencer: captures EPC, reads the handler address from memory with a configurable read latency, then loads it into PC.
- Sits between the datapath sources (ALU result, ALUOut, jump target, EPC, MDR) and the instruction-fetch address.

Parameters:
- WIDTH, 32, data/PC width in bits
- NSRC, 5, number of PC source inputs (2..8)
- SELW, 3, select width; must satisfy 2**SELW >= NSRC
- RESET_VECTOR, 0, PC value on reset
- EXC_BASE, 253, memory address of the first exception-vector word
- MEM_LAT, 1, memory read latency in cycles (>=1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- src_sel  in  SELW  PC source select
- src_data  in  NSRC*WIDTH  packed sources; source i occupies bits [i*WIDTH +: WIDTH]
- pc_write  in  1  unconditional PC write
- pc_write_cond  in  1  conditional PC write (branch)
- cond_flag  in  1  branch condition (e.g. ALU zero)
- exc_req  in  1  exception request, level-sampled
- exc_code  in  2  exception cause; selects the vector word
- mem_rdata  in  WIDTH  memory read data for the vector fetch
- pc  out  WIDTH  current PC
- epc  out  WIDTH  exception PC
- exc_addr  out  WIDTH  vector address driven to memory
- exc_mem_rd  out  1  memory read request during the vector fetch
- busy  out  1  high while the sequencer is not IDLE
- exc_ack  out  1  one-cycle pulse after the handler PC is loaded
- illegal_sel  out  1  one-cycle pulse on a write with src_sel >= NSRC

Behaviour:
- Reset (async, any state): pc=RESET_VECTOR; epc=0; exc_addr=0; exc_mem_rd=0; busy=0; exc_ack=0; illegal_sel=0; state=IDLE; wait counter=0.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- States: IDLE, EXC_RD.
- IDLE:
  - Define load = pc_write | (pc_write_cond & cond_flag).
  - exc_req=1 has priority over load. On that edge: epc <= pc - 4 (modulo 2**WIDTH; pc=0 gives all-ones minus 3); exc_addr <= EXC_BASE + exc_code; counter <= MEM_LAT; go to EXC_RD. pc holds.
  - Otherwise, load=1 with src_sel < NSRC: pc <= source[src_sel] on that edge (1-cycle latency).
  - Otherwise, load=1 with src_sel >= NSRC: pc holds; illegal_sel=1 for the next cycle.
  - load=0: pc holds.
- EXC_RD:
  - busy=1 and exc_mem_rd=1 throughout; exc_addr stable.
  - pc_write, pc_write_cond and exc_req are ignored; a request still high on return to IDLE is taken again.
  - counter decrements each edge. On the edge where counter==1: pc <= mem_rdata; return to IDLE; exc_ack=1 for the following cycle.
  - EXC_RD lasts exactly MEM_LAT cycles. pc changes MEM_LAT+1 edges after exc_req is sampled.
- exc_ack and illegal_sel are single-cycle pulses and self-clear on the next edge.
- epc changes only on exception entry and on reset.
- Reset asserted during EXC_RD aborts the fetch immediately: exc_mem_rd and busy drop asynchronously, and the partially fetched vector is discarded.
- pc_write and pc_write_cond asserted together: pc_write dominates (load=1 regardless of cond_flag).

Test Plan:
- Reset, then pc_write=1, src_sel=2, src_data[2]=0x0000_0040 -> pc=0x40 one edge later; epc=0; busy=0.
- pc_write_cond=1, cond_flag=0, src_sel=0 -> pc unchanged. Repeat with cond_flag=1, src_data[0]=0x88 -> pc=0x88.
- pc_write=1, src_sel=6 (NSRC=5) -> pc unchanged; illegal_sel high exactly one cycle.
- pc=0x104, exc_req=1, exc_code=1, MEM_LAT=2, mem_rdata=0x0000_0080 -> epc=0x100; exc_addr=254; exc_mem_rd/busy high 2 cycles; pc=0x80 at the 3rd edge; exc_ack one cycle. Simultaneous pc_write during the fetch is ignored.
- exc_req and pc_write both high in IDLE -> the exception wins, and pc is not loaded from src_data. With pc=0 -> epc=0xFFFF_FFFC.
- Assert reset mid EXC_RD (asynchronous, between edges) -> pc=RESET_VECTOR, epc=0, busy=0, exc_mem_rd=0 immediately; no exc_ack after release.
